// File: rtl/weight_prefetch_buffer_if.sv
// weight_prefetch_buffer_if: write port, prefetch control and active weight outputs
interface weight_prefetch_buffer_if #(
  parameter int NB_PE_COL    = 32,
  parameter int NB_TAPS      = 5,
  parameter int WEIGHT_WIDTH = 16,
  parameter int BUFFER_DEPTH = 72
);
  localparam int ADDR_WIDTH    = $clog2(BUFFER_DEPTH);
  localparam int TAP_CNT_WIDTH = $clog2(NB_TAPS + 1);
  logic [NB_PE_COL-1:0]                      wr_en;
  logic [ADDR_WIDTH-1:0]                     wr_addr;
  logic [NB_PE_COL*WEIGHT_WIDTH-1:0]         wr_data;
  logic                                      wr_ready;
  logic                                      load_start;
  logic [ADDR_WIDTH-1:0]                     load_base;
  logic [TAP_CNT_WIDTH-1:0]                  load_ntaps;
  logic                                      busy;
  logic                                      shadow_valid;
  logic                                      swap;
  logic                                      w_valid;
  logic [NB_PE_COL*NB_TAPS*WEIGHT_WIDTH-1:0] wregs;
  logic                                      load_err;
  modport master (
    output wr_en, wr_addr, wr_data, load_start, load_base, load_ntaps, swap,
    input  wr_ready, busy, shadow_valid, w_valid, wregs, load_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, load_start, load_base, load_ntaps, swap,
    output wr_ready, busy, shadow_valid, w_valid, wregs, load_err
  );
endinterface

// File: rtl/weight_prefetch_buffer.sv
// weight_prefetch_buffer: per-column weight banks prefetched into a shadow tap set,
// promoted to the active registers on swap.
module weight_prefetch_buffer #(
  parameter int NB_PE_COL    = 32,
  parameter int NB_TAPS      = 5,
  parameter int WEIGHT_WIDTH = 16,
  parameter int BUFFER_DEPTH = 72
) (
  input logic                   clk,
  input logic                   rst_n,
  weight_prefetch_buffer_if.slave bus
);
  localparam int ADDR_WIDTH    = $clog2(BUFFER_DEPTH);
  localparam int TAP_CNT_WIDTH = $clog2(NB_TAPS + 1);
  localparam int ROW_WIDTH     = NB_PE_COL * WEIGHT_WIDTH;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] READY = 2'd3;
  logic [1:0]                                state_q, state_d;
  logic [ROW_WIDTH-1:0]                      rd_data;
  logic [ROW_WIDTH-1:0]                      shadow_q [NB_TAPS];
  logic [NB_PE_COL*NB_TAPS*WEIGHT_WIDTH-1:0] wregs_q, swap_val;
  logic [ADDR_WIDTH-1:0]                     addr_q;
  logic [TAP_CNT_WIDTH-1:0]                  n_q, k_q, rd_idx_q, n_clamp;
  logic                                      rd_v_q, busy_q, shadow_valid_q, w_valid_q, load_err_q;
  logic                                      wr_ready, load_ok, load_go, swap_go, rd_en;
  assign wr_ready = state_q == IDLE || state_q == READY;
  assign load_ok  = wr_ready && bus.load_start;
  assign load_go  = load_ok && bus.load_ntaps != '0;
  assign swap_go  = bus.swap && shadow_valid_q;
  assign rd_en    = state_q == READ && k_q != n_q;
  assign n_clamp  = bus.load_ntaps > TAP_CNT_WIDTH'(NB_TAPS) ? TAP_CNT_WIDTH'(NB_TAPS) : bus.load_ntaps;
  // READ spends one extra cycle after the last issue so the final word lands before DRAIN
  assign state_d  = load_go ? READ
                  : swap_go ? IDLE
                  : (state_q == READ && k_q == n_q) ? DRAIN
                  : state_q == DRAIN ? READY : state_q;
  for (genvar c = 0; c < NB_PE_COL; c++) begin : g_bank
    logic [WEIGHT_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [WEIGHT_WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_ready && bus.wr_en[c]) mem[bus.wr_addr] <= bus.wr_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (rd_en) rd_q <= mem[addr_q];
    end
    assign rd_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = rd_q;
    for (genvar t = 0; t < NB_TAPS; t++) begin : g_tap
      assign swap_val[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = shadow_q[t][c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      shadow_valid_q <= 1'b0;
      w_valid_q      <= 1'b0;
      load_err_q     <= 1'b0;
      rd_v_q         <= 1'b0;
      rd_idx_q       <= '0;
      k_q            <= '0;
      n_q            <= '0;
      addr_q         <= '0;
      wregs_q        <= '0;
      shadow_q       <= '{default: '0};
    end else begin
      state_q        <= state_d;
      busy_q         <= state_d == READ || state_d == DRAIN;
      load_err_q     <= load_ok && bus.load_ntaps == '0;
      rd_v_q         <= rd_en;
      rd_idx_q       <= k_q;
      shadow_valid_q <= (load_go || swap_go) ? 1'b0 : state_q == DRAIN ? 1'b1 : shadow_valid_q;
      if (rd_en) begin
        k_q    <= k_q + 1'b1;
        addr_q <= addr_q == ADDR_WIDTH'(BUFFER_DEPTH - 1) ? '0 : addr_q + 1'b1;
      end
      if (swap_go) begin
        wregs_q   <= swap_val;
        w_valid_q <= 1'b1;
      end
      if (load_go) begin
        n_q      <= n_clamp;
        k_q      <= '0;
        addr_q   <= bus.load_base;
        shadow_q <= '{default: '0};
      end else if (rd_v_q) begin
        shadow_q[rd_idx_q] <= rd_data;
      end
    end
  end
  assign bus.wr_ready     = wr_ready;
  assign bus.busy         = busy_q;
  assign bus.shadow_valid = shadow_valid_q;
  assign bus.w_valid      = w_valid_q;
  assign bus.wregs        = wregs_q;
  assign bus.load_err     = load_err_q;
endmodule
